// File: rtl/seven_seg_scan_driver_if.sv
// seven_seg_scan_driver_if: display value/control inputs and scanned pin outputs (master drives value, dp_in, load, lz_suppress, blank; slave drives segments, dp, digit_en, frame_done)
interface seven_seg_scan_driver_if #(parameter int NUM_DIGITS = 4);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    lz_suppress;
  logic                    blank;
  logic [6:0]              segments;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    frame_done;
  modport master (output value, dp_in, load, lz_suppress, blank, input segments, dp, digit_en, frame_done);
  modport slave (input value, dp_in, load, lz_suppress, blank, output segments, dp, digit_en, frame_done);
endinterface

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed N-digit 7-segment driver (clk, rst_n async active-low, bus = slave side of seven_seg_scan_driver_if)
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int GHOST_CYCLES   = 2,
  parameter bit HEX_MODE       = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input logic clk,
  input logic rst_n,
  seven_seg_scan_driver_if.slave bus
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int VW = 4*NUM_DIGITS;
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [VW-1:0] pend_q, pend_d, disp_q, disp_d;
  logic [NUM_DIGITS-1:0] pdp_q, pdp_d, ddp_q, ddp_d, en_q, en_d, lead;
  logic pend_valid_q, pend_valid_d, fd_q, boundary, slot_end, lz_run, off;
  logic [6:0] seg_q, seg_d;
  logic dp_q, dp_d;
  logic [3:0] nib;
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return HEX_MODE ? 7'b1110111 : 7'b0000000;
      4'hB: return HEX_MODE ? 7'b0011111 : 7'b0000000;
      4'hC: return HEX_MODE ? 7'b1001110 : 7'b0000000;
      4'hD: return HEX_MODE ? 7'b0111101 : 7'b0000000;
      4'hE: return HEX_MODE ? 7'b1001111 : 7'b0000000;
      default: return HEX_MODE ? 7'b1000111 : 7'b0000000;
    endcase
  endfunction
  always_comb begin
    slot_end = presc_q == PW'(SCAN_DIV-1);
    boundary = slot_end && idx_q == IW'(NUM_DIGITS-1);
    presc_d = slot_end ? '0 : presc_q + 1'b1;
    idx_d = !slot_end ? idx_q : idx_q == IW'(NUM_DIGITS-1) ? '0 : idx_q + 1'b1;
    pend_d = bus.load ? bus.value : pend_q;
    pdp_d = bus.load ? bus.dp_in : pdp_q;
    pend_valid_d = !boundary && (bus.load || pend_valid_q);
    // A load on the boundary cycle bypasses the pending register
    disp_d = !boundary ? disp_q : bus.load ? bus.value : pend_valid_q ? pend_q : disp_q;
    ddp_d = !boundary ? ddp_q : bus.load ? bus.dp_in : pend_valid_q ? pdp_q : ddp_q;
    // lead[k]: digits NUM_DIGITS-1..k are all zero with no decimal point
    lead = '0;
    lz_run = 1'b1;
    for (int k = NUM_DIGITS-1; k >= 0; k--) begin
      lz_run = lz_run & (disp_q[4*k +: 4] == 4'd0) & ~ddp_q[k];
      lead[k] = lz_run;
    end
    nib = disp_q[4*idx_q +: 4];
    off = bus.blank || (bus.lz_suppress && idx_q != '0 && lead[idx_q]);
    seg_d = off ? 7'd0 : decode(nib);
    dp_d = !off && ddp_q[idx_q];
    en_d = presc_q >= PW'(GHOST_CYCLES) ? NUM_DIGITS'(1) << idx_q : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      presc_q <= '0;
      idx_q <= '0;
      pend_q <= '0;
      pdp_q <= '0;
      pend_valid_q <= 1'b0;
      disp_q <= '0;
      ddp_q <= '0;
      seg_q <= '0;
      dp_q <= 1'b0;
      en_q <= '0;
      fd_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q <= idx_d;
      pend_q <= pend_d;
      pdp_q <= pdp_d;
      pend_valid_q <= pend_valid_d;
      disp_q <= disp_d;
      ddp_q <= ddp_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
      en_q <= en_d;
      fd_q <= boundary;
    end
  assign bus.segments = seg_q ^ {7{SEG_ACTIVE_LOW}};
  assign bus.dp = dp_q ^ SEG_ACTIVE_LOW;
  assign bus.digit_en = en_q ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: vector table, frame-sync sequences and random stimulus against an arithmetic reference model
module tb_seven_seg_scan_driver;
  localparam int N = 4, SD = 4, G = 1, FR = N*SD;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  seven_seg_scan_driver_if #(.NUM_DIGITS(N)) bus_a ();
  seven_seg_scan_driver_if #(.NUM_DIGITS(N)) bus_b ();
  seven_seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .GHOST_CYCLES(G), .HEX_MODE(1'b0),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  seven_seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .GHOST_CYCLES(G), .HEX_MODE(1'b1),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  assign bus_b.value = bus_a.value;
  assign bus_b.dp_in = bus_a.dp_in;
  assign bus_b.load = bus_a.load;
  assign bus_b.lz_suppress = bus_a.lz_suppress;
  assign bus_b.blank = bus_a.blank;
  logic [6:0] dec [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
  logic [6:0] hex [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  typedef struct packed {
    logic [15:0] v;
    logic [3:0] dp;
    logic lz;
    logic bl;
    logic [3:0][6:0] s;
    logic [3:0] edp;
  } vec_t;
  vec_t tab [9];
  int total = 0, bad = 0, cyc = 0;
  logic [15:0] m_disp = '0, m_pend = '0;
  logic [3:0] m_ddp = '0, m_pdp = '0;
  bit m_pv = 0;
  logic [6:0] cap_a [4], cap_b [4];
  logic [3:0] cap_dp;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  task automatic clear_cap();
    for (int i = 0; i < 4; i++) begin
      cap_a[i] = 7'h55;
      cap_b[i] = 7'h55;
    end
    cap_dp = 4'hx;
  endtask

  task automatic tick();
    int presc, idx;
    bit bnd, off;
    logic [3:0] en, enn, nib;
    logic [6:0] es, ehn;
    logic edp, edpn;
    @(posedge clk);
    presc = cyc % SD;
    idx = (cyc / SD) % N;
    bnd = idx == N-1 && presc == SD-1;
    en = presc >= G ? 4'(1 << idx) : 4'd0;
    enn = ~en;
    nib = 4'(m_disp >> (4*idx));
    off = bus_a.blank || (bus_a.lz_suppress && idx > 0 && (m_disp >> (4*idx)) == 0 && (m_ddp >> idx) == 0);
    es = off ? 7'd0 : dec[nib];
    ehn = ~(off ? 7'd0 : hex[nib]);
    edp = !off && m_ddp[idx];
    edpn = ~edp;
    if (bnd) begin
      if (bus_a.load) begin
        m_disp = bus_a.value;
        m_ddp = bus_a.dp_in;
      end else if (m_pv) begin
        m_disp = m_pend;
        m_ddp = m_pdp;
      end
      m_pv = 0;
    end else if (bus_a.load) m_pv = 1;
    if (bus_a.load) begin
      m_pend = bus_a.value;
      m_pdp = bus_a.dp_in;
    end
    cyc++;
    #1;
    chk("en_a", bus_a.digit_en, en);
    chk("en_b", bus_b.digit_en, enn);
    chk("fd_a", bus_a.frame_done, bnd);
    chk("fd_b", bus_b.frame_done, bnd);
    if (en != 0) begin
      chk("seg_a", bus_a.segments, es);
      chk("dp_a", bus_a.dp, edp);
      chk("seg_b", bus_b.segments, ehn);
      chk("dp_b", bus_b.dp, edpn);
      cap_a[idx] = bus_a.segments;
      cap_b[idx] = bus_b.segments;
      cap_dp[idx] = bus_a.dp;
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    bus_a.load = 1'b0;
    #1;
    chk("rst_en_a", bus_a.digit_en, 4'b0000);
    chk("rst_seg_a", bus_a.segments, 7'b0000000);
    chk("rst_dp_a", bus_a.dp, 1'b0);
    chk("rst_fd_a", bus_a.frame_done, 1'b0);
    chk("rst_en_b", bus_b.digit_en, 4'b1111);
    chk("rst_seg_b", bus_b.segments, 7'b1111111);
    chk("rst_dp_b", bus_b.dp, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    m_disp = '0;
    m_pend = '0;
    m_ddp = '0;
    m_pdp = '0;
    m_pv = 0;
    tick();
    chk("rel_dark", bus_a.digit_en, 4'b0000);
    tick();
    chk("rel_first", bus_a.digit_en, 4'b0001);
  endtask

  task automatic load_val(input logic [15:0] v, input logic [3:0] d);
    bus_a.value = v;
    bus_a.dp_in = d;
    bus_a.load = 1'b1;
    tick();
    bus_a.load = 1'b0;
  endtask

  initial begin
    logic [6:0] inv;
    logic [15:0] mask;
    bus_a.value = '0;
    bus_a.dp_in = '0;
    bus_a.load = 1'b0;
    bus_a.lz_suppress = 1'b0;
    bus_a.blank = 1'b0;
    tab[0] = '{16'h1234, 4'b0000, 1'b0, 1'b0, {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}, 4'b0000};
    tab[1] = '{16'h0040, 4'b0000, 1'b1, 1'b0, {7'b0000000, 7'b0000000, 7'b0110011, 7'b1111110}, 4'b0000};
    tab[2] = '{16'h0000, 4'b0000, 1'b1, 1'b0, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}, 4'b0000};
    tab[3] = '{16'h0040, 4'b0100, 1'b1, 1'b0, {7'b0000000, 7'b1111110, 7'b0110011, 7'b1111110}, 4'b0100};
    tab[4] = '{16'hABCD, 4'b0000, 1'b0, 1'b0, {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000}, 4'b0000};
    tab[5] = '{16'h0000, 4'b0000, 1'b0, 1'b0, {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}, 4'b0000};
    tab[6] = '{16'h8000, 4'b0001, 1'b1, 1'b0, {7'b1111111, 7'b1111110, 7'b1111110, 7'b1111110}, 4'b0001};
    tab[7] = '{16'h8888, 4'b1111, 1'b0, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000}, 4'b0000};
    tab[8] = '{16'h0905, 4'b0000, 1'b1, 1'b0, {7'b0000000, 7'b1111011, 7'b1111110, 7'b1011011}, 4'b0000};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus_a.lz_suppress = tab[i].lz;
      bus_a.blank = tab[i].bl;
      load_val(tab[i].v, tab[i].dp);
      repeat (2*FR) tick();
      clear_cap();
      repeat (FR) tick();
      for (int k = 0; k < 4; k++) chk($sformatf("vec%0d_d%0d", i, k), cap_a[k], tab[i].s[k]);
      chk($sformatf("vec%0d_dp", i), cap_dp, tab[i].edp);
      if (tab[i].v == 16'hABCD) begin
        inv = ~cap_b[0];
        chk("hex_d", inv, 7'b0111101);
        inv = ~cap_b[3];
        chk("hex_a", inv, 7'b1110111);
      end
    end
    bus_a.lz_suppress = 1'b0;
    bus_a.blank = 1'b0;
    load_val(16'h1234, 4'b0000);
    repeat (2*FR) tick();
    while (cyc % FR != 6) tick();
    load_val(16'h5678, 4'b0000);
    while (cyc % FR != 10) tick();
    load_val(16'h9999, 4'b0000);
    clear_cap();
    while (cyc % FR != 0) tick();
    chk("sync_old_d3", cap_a[3], 7'b0110000);
    chk("sync_old_d2", cap_a[2], 7'b1101101);
    clear_cap();
    repeat (FR) tick();
    for (int k = 0; k < 4; k++) chk($sformatf("sync_new_d%0d", k), cap_a[k], 7'b1111011);
    while (cyc % FR != FR-1) tick();
    load_val(16'h2222, 4'b0000);
    clear_cap();
    repeat (FR) tick();
    for (int k = 0; k < 4; k++) chk($sformatf("bypass_d%0d", k), cap_a[k], 7'b1101101);
    for (int i = 0; i < 900; i++) begin
      if (i == 450) do_reset();
      if ($urandom_range(0, 49) == 0) bus_a.lz_suppress = ~bus_a.lz_suppress;
      if ($urandom_range(0, 39) == 0) bus_a.blank = ~bus_a.blank;
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: mask = 16'hFFFF;
          1: mask = 16'h00FF;
          2: mask = 16'h000F;
          default: mask = 16'h0000;
        endcase
        bus_a.value = 16'($urandom) & mask;
        bus_a.dp_in = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'b0000;
        bus_a.load = 1'b1;
      end else bus_a.load = 1'b0;
      tick();
    end
    bus_a.load = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
